// File: rtl/seq_det_pkg.sv
// Shared defaults and sizing helpers for the serial pattern detector.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package seq_det_pkg;

  localparam int DEF_SEQ_LEN = 4;
  localparam logic [DEF_SEQ_LEN-1:0] DEF_SEQ = 4'b1010;

  // Bits needed to hold a fill count in the range 0..n inclusive.
  function automatic int fill_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones.
// Latency: count updates on the edge after inc is seen.
// Backpressure: none; inc while saturated is dropped.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Counter register: clear wins over increment, increment stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with reloadable pattern and match counter.
// Latency: z pulses one cycle after the edge that samples the final pattern bit.
// Backpressure: none; en qualifies x, clr and pat_load take priority over sampling.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ     = DEF_SEQ,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               x,
  input  logic               en,
  input  logic               clr,
  input  logic               pat_load,
  input  logic [SEQ_LEN-1:0] pattern,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int FW = fill_w(SEQ_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(SEQ_LEN);

  // Only the newest SEQ_LEN-1 bits need storing: the oldest bit of the window
  // is shifted out on the very edge that compares, so it never matters.
  logic [SEQ_LEN-2:0] hist;
  logic [FW-1:0]      fill;
  logic [SEQ_LEN-1:0] pat_q;

  logic [SEQ_LEN-1:0] hist_n;
  logic [FW-1:0]      fill_inc;
  logic               sample;
  logic               match;

  // Candidate window and fill count for a sampling edge; match only on a plain sample.
  always_comb begin
    sample   = en && !clr && !pat_load;
    hist_n   = {hist, x};
    fill_inc = (fill == FILL_MAX) ? fill : fill + 1'b1;
    match    = sample && (fill_inc == FILL_MAX) && (hist_n == pat_q);
  end

  // History, fill, pattern and match pulse with clr > pat_load > en priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= SEQ;
      hist  <= '0;
      fill  <= '0;
      z     <= 1'b0;
    end else if (clr) begin
      hist  <= '0;
      fill  <= '0;
      z     <= 1'b0;
    end else if (pat_load) begin
      pat_q <= pattern;
      hist  <= '0;
      fill  <= '0;
      z     <= 1'b0;
    end else if (en) begin
      hist  <= hist_n[SEQ_LEN-2:0];
      // Non-overlap mode restarts the window after a hit; stale bits stay but fill masks them.
      fill  <= (match && !OVERLAP) ? '0 : fill_inc;
      z     <= match;
    end else begin
      z     <= 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (match),
    .cnt   (match_cnt)
  );

endmodule
